load_align_reader: RTL and testbench
====================================

# load_align_reader

Memory-stage load reader: the read-side counterpart of the execute-stage store shifter/masker. It accepts one load at a time from the pipeline and issues a word-aligned read over a valid/ready memory port. It then selects and sign- or zero-extends the addressed byte, halfword or word, and holds the result for writeback until consumed. Misaligned and illegal loads never reach memory and are reported with an error code. Flush and a response timeout are supported.

## Interface
- TIMEOUT, 16: cycles waited for a memory response before a timeout error (≥2).
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill in-flight load (pipeline redirect).
- req_valid_M  in  1  load request present.
- req_ready_M  out  1  block can accept a request.
- funct3_M  in  3  RV32I load funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- addr_M  in  32  byte address (ALU result).
- rd_M  in  5  destination register.
- mem_req_valid  out  1  read request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_resp_valid  in  1  read data valid (one-cycle pulse per accepted request).
- mem_resp_data  in  32  read word, little-endian.
- load_valid_W  out  1  result available.
- wb_ready_W  in  1  writeback consumes result.
- load_data_W  out  32  extended load data (0 on error).
- load_rd_W  out  5  destination register.
- load_err_W  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
- busy_M  out  1  state ≠ IDLE; used as pipeline stall.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE. Reset → IDLE. All outputs reset to 0; internal counter and latches also reset to 0.
- req_ready_M = (state==IDLE) & ~flush. Accept = req_valid_M & req_ready_M. On accept, latch funct3, addr[1:0], rd and word address.
- Check on accept, in priority order:
  - funct3 ∉ {000,001,010,100,101} → DONE, err=10.
  - LH/LHU with addr[0]=1, or LW with addr[1:0]≠00 → DONE, err=01.
  - Otherwise → REQ.
  - Error paths issue no mem_req.
- REQ: mem_req_valid=1, addr stable. mem_req_ready → WAIT, counter cleared.
- WAIT: counter increments each cycle. On mem_resp_valid, extract and extend, register into load_data_W, → DONE with err=00. If counter reaches TIMEOUT-1 with no response → DONE, err=11.
- Extraction by offset o=addr[1:0]:
  - byte = data[8o+7:8o]; LB sign-extends from bit 7, LBU zero-extends.
  - half = data[16(o>>1)+15:16(o>>1)]; LH sign-extends from bit 15, LHU zero-extends.
  - LW passes the word unchanged.
- DONE: load_valid_W=1; data/rd/err held stable. wb_ready_W → IDLE next cycle. There is no same-cycle re-accept in DONE.
- DRAIN: waits for the stale response, then discards it and → IDLE. The timeout counter also applies here: reaching TIMEOUT-1 → IDLE silently.
- Flush, taking priority over all other transitions:
  - IDLE: nothing accepted.
  - REQ with mem_req_ready=0: → IDLE; the request is withdrawn.
  - REQ with mem_req_ready=1: → DRAIN.
  - WAIT without response: → DRAIN.
  - WAIT with mem_resp_valid the same cycle: → IDLE, data discarded.
  - DONE: → IDLE; load_valid_W falls.
  - DRAIN: no effect.
- mem_resp_valid outside WAIT/DRAIN is ignored. The memory contract is at most one outstanding read and no response after a timeout; a timeout is treated as fatal.
- load_data_W is forced to 0 whenever err≠00.

## Timing
- Accept in cycle N → mem_req_valid high in N+1.
- Ready in N+1 → earliest response in N+2 → load_valid_W in N+3. Minimum latency is 3 cycles.
- Error path: accept in N → load_valid_W in N+1.
- A timeout asserts load_valid_W exactly TIMEOUT cycles after entering WAIT.
- After wb_ready_W in DONE at cycle M, req_ready_M is high in M+1.
- rst asserted in any state → IDLE and all outputs 0 on the next edge; an in-flight response is ignored after reset.

## Test plan
- LB at addr 0x1003, response 0x80FF_1234:
  - mem_req_addr=0x1000 and load_data_W=0xFFFF_FF80.
  - LBU at the same address gives 0x0000_0080.
  - load_valid_W at N+3 with zero-wait memory.
- LH at addr 0x2002, response 0x80FF_1234 → 0xFFFF_80FF. LHU → 0x0000_80FF. LW at 0x2000 → 0x80FF_1234.
- LW at 0x1002 and LH at 0x1001 → no mem_req_valid, load_valid_W at N+1, err=01, data=0. Funct3=011 → err=10.
- Flush during WAIT, then response 2 cycles later → no load_valid_W; busy_M stays high through DRAIN; req_ready_M returns the cycle after the response.
- Memory never responds with TIMEOUT=16 → err=11 exactly 16 cycles after entering WAIT, data=0. Hold wb_ready_W low 3 cycles → data/rd/err stable; IDLE one cycle after wb_ready_W.
- Assert rst in REQ and then in DONE → all outputs 0 next cycle; a subsequent LW completes normally.

Source files
------------

// File: rtl/load_align_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_reader                                                        |
// | Memory-stage load reader: aligned word read, byte/half select + extend.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_align_reader #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid_M,
    output logic        req_ready_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [4:0]  rd_M,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        load_valid_W,
    input  logic        wb_ready_W,
    output logic [31:0] load_data_W,
    output logic [4:0]  load_rd_W,
    output logic [1:0]  load_err_W,
    output logic        busy_M
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_misal   = 2'b01;
    localparam logic [1:0] c_err_illegal = 2'b10;
    localparam logic [1:0] c_err_timeout = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [29:0]     waddr_q, waddr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic [1:0]      err_q, err_d;

    logic            w_accept;
    logic            w_legal;
    logic            w_misal;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_extract;

    assign req_ready_M   = (state_q == S_IDLE) & ~flush;
    assign w_accept      = req_valid_M & req_ready_M;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = {waddr_q, 2'b00};
    assign load_valid_W  = (state_q == S_DONE);
    assign busy_M        = (state_q != S_IDLE);
    assign load_data_W   = (err_q == c_err_ok) ? data_q : 32'd0;
    assign load_rd_W     = rd_q;
    assign load_err_W    = err_q;

    // Legality and alignment are judged on the incoming request, not the latches.
    always_comb begin
        w_legal = 1'b0;
        case (funct3_M)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
        w_misal = ((funct3_M[1:0] == 2'b01) && addr_M[0]) ||
                  ((funct3_M[1:0] == 2'b10) && (addr_M[1:0] != 2'b00));
    end

    always_comb begin
        w_byte = mem_resp_data[7:0];
        case (off_q)
            2'd0:    w_byte = mem_resp_data[7:0];
            2'd1:    w_byte = mem_resp_data[15:8];
            2'd2:    w_byte = mem_resp_data[23:16];
            default: w_byte = mem_resp_data[31:24];
        endcase
        w_half = off_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        case (f3_q)
            3'b000:  w_extract = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_extract = {24'd0, w_byte};
            3'b001:  w_extract = {{16{w_half[15]}}, w_half};
            3'b101:  w_extract = {16'd0, w_half};
            default: w_extract = mem_resp_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    f3_d    = funct3_M;
                    off_d   = addr_M[1:0];
                    rd_d    = rd_M;
                    waddr_d = addr_M[31:2];
                    if (!w_legal) begin
                        state_d = S_DONE;
                        err_d   = c_err_illegal;
                        data_d  = 32'd0;
                    end else if (w_misal) begin
                        state_d = S_DONE;
                        err_d   = c_err_misal;
                        data_d  = 32'd0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A handshake completing under flush still owes us a response.
                if (flush) begin
                    state_d = mem_req_ready ? S_DRAIN : S_IDLE;
                    cnt_d   = '0;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (flush) begin
                    state_d = mem_resp_valid ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid) begin
                    state_d = S_DONE;
                    data_d  = w_extract;
                    err_d   = c_err_ok;
                end else if (cnt_q >= c_cnt_last) begin
                    state_d = S_DONE;
                    data_d  = 32'd0;
                    err_d   = c_err_timeout;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_resp_valid || (cnt_q >= c_cnt_last)) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush || wb_ready_W) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rd_q    <= 5'd0;
            waddr_q <= 30'd0;
            cnt_q   <= '0;
            data_q  <= 32'd0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_align_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_align_reader                                                     |
// | Scripted-transaction bench with a load-semantics reference model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_load_align_reader;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid_M, req_ready_M;
    logic [2:0]  funct3_M;
    logic [31:0] addr_M;
    logic [4:0]  rd_M;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        load_valid_W, wb_ready_W;
    logic [31:0] load_data_W;
    logic [4:0]  load_rd_W;
    logic [1:0]  load_err_W;
    logic        busy_M;

    load_align_reader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid_M(req_valid_M), .req_ready_M(req_ready_M),
        .funct3_M(funct3_M), .addr_M(addr_M), .rd_M(rd_M),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .load_valid_W(load_valid_W),
        .wb_ready_W(wb_ready_W), .load_data_W(load_data_W),
        .load_rd_W(load_rd_W), .load_err_W(load_err_W), .busy_M(busy_M)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit          chk_en = 1'b0;
    bit          e_busy, e_memreq, e_valid, e_ready, e_full;
    logic [31:0] e_addr, e_data;
    logic [4:0]  e_rd;
    logic [1:0]  e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference semantics: error code and extended value of a load.
    function automatic int model_err(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 2;
        if ((a % (32'd1 << f3[1:0])) != 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_extract(input logic [2:0] f3, input logic [31:0] a,
                                                  input logic [31:0] w);
        int     nbytes;
        longint v;
        nbytes = 1 << f3[1:0];
        v = longint'(w) >> (8 * int'(a[1:0]));
        if (nbytes < 4) begin
            v = v % (longint'(1) << (8 * nbytes));
            if (!f3[2] && v >= (longint'(1) << (8 * nbytes - 1)))
                v = v - (longint'(1) << (8 * nbytes));
        end
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_M", {31'd0, busy_M}, {31'd0, e_busy});
            chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, e_memreq});
            chk("load_valid_W", {31'd0, load_valid_W}, {31'd0, e_valid});
            chk("req_ready_M", {31'd0, req_ready_M}, {31'd0, e_ready});
            if (e_memreq || e_full) chk("mem_req_addr", mem_req_addr, e_addr);
            if (e_valid || e_full) begin
                chk("load_data_W", load_data_W, e_data);
                chk("load_rd_W", {27'd0, load_rd_W}, {27'd0, e_rd});
                chk("load_err_W", {30'd0, load_err_W}, {30'd0, e_err});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 0; flush = 0; req_valid_M = 0; mem_req_ready = 0;
        mem_resp_valid = 0; wb_ready_W = 0;
        funct3_M = 3'($urandom); addr_M = $urandom; rd_M = 5'($urandom);
        mem_resp_data = $urandom;
    endtask

    task automatic exp_set(input bit busy, input bit memreq, input bit valid, input bit full,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [4:0] r, input logic [1:0] e);
        e_busy = busy; e_memreq = memreq; e_valid = valid; e_full = full;
        e_addr = a; e_data = d; e_rd = r; e_err = e;
        e_ready = !busy && !flush;
    endtask

    task automatic exp_idle();
        exp_set(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic after_reset();
        tick(); clr();
        exp_set(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int d = 0; d <= n; d++) begin
            tick(); clr();
            mem_resp_valid = (d == n);
            exp_set(1, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); clr();
            flush = ($urandom % 4 == 0);
            req_valid_M = flush ? 1'($urandom) : 1'b0;
            mem_resp_valid = ($urandom % 4 == 0);
            exp_idle();
        end
    endtask

    // mode: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in DONE,
    //       4 reset in REQ, 5 reset in DONE; 'at' is the cycle index within that phase.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] w, input int rdy, input int rsp, input int wb,
                           input int mode, input int at, input int dd);
        int          err;
        logic [31:0] ed;
        logic [31:0] wa;
        err = model_err(f3, a);
        ed  = (err != 0) ? 32'd0 : model_extract(f3, a, w);
        wa  = a & ~32'd3;
        tick(); clr();
        req_valid_M = 1; funct3_M = f3; addr_M = a; rd_M = rd;
        exp_idle();
        if (err == 0) begin
            for (int i = 0; i <= rdy; i++) begin
                tick(); clr();
                mem_req_ready = (i == rdy);
                if (mode == 1 && at == i) flush = 1;
                if (mode == 4 && at == i) rst = 1;
                exp_set(1, 1, 0, 0, wa, 0, 0, 0);
                if (mode == 1 && at == i) begin
                    if (i == rdy) drain(dd);
                    return;
                end
                if (mode == 4 && at == i) begin
                    after_reset();
                    return;
                end
            end
            for (int j = 0; j < TIMEOUT; j++) begin
                tick(); clr();
                mem_resp_valid = (j == rsp);
                if (j == rsp) mem_resp_data = w;
                if (mode == 2 && at == j) flush = 1;
                exp_set(1, 0, 0, 0, 0, 0, 0, 0);
                if (mode == 2 && at == j) begin
                    if (j != rsp) drain(rsp - j - 1);
                    return;
                end
                if (j == rsp) break;
            end
            if (rsp >= TIMEOUT) begin
                err = 3;
                ed  = 0;
            end
        end
        for (int k = 0; k <= wb; k++) begin
            tick(); clr();
            wb_ready_W = (k == wb);
            mem_resp_valid = ($urandom % 4 == 0);
            if (mode == 3 && at == k) flush = 1;
            if (mode == 5 && at == k) rst = 1;
            exp_set(1, 0, 1, 0, 0, ed, rd, 2'(err));
            if (mode == 3 && at == k) return;
            if (mode == 5 && at == k) begin
                after_reset();
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] legal_f3 [5];
        logic [2:0] bad_f3 [3];
        logic [2:0] f3;
        logic [31:0] a;
        int rdy, rsp, wb, mode, at, dd;
        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad_f3   = '{3'b011, 3'b110, 3'b111};

        // Pin the reference model to hand-computed values.
        chk("model_lb",  model_extract(3'b000, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("model_lbu", model_extract(3'b100, 32'h1003, 32'h80FF_1234), 32'h0000_0080);
        chk("model_lh",  model_extract(3'b001, 32'h2002, 32'h80FF_1234), 32'hFFFF_80FF);
        chk("model_lhu", model_extract(3'b101, 32'h2002, 32'h80FF_1234), 32'h0000_80FF);
        chk("model_lw",  model_extract(3'b010, 32'h2000, 32'h80FF_1234), 32'h80FF_1234);
        chk("model_lb0", model_extract(3'b000, 32'h2000, 32'h80FF_1234), 32'h0000_0034);
        chk("model_err_lw",  32'(model_err(3'b010, 32'h1002)), 32'd1);
        chk("model_err_lh",  32'(model_err(3'b001, 32'h1001)), 32'd1);
        chk("model_err_f3",  32'(model_err(3'b011, 32'h1000)), 32'd2);
        chk("model_err_ok",  32'(model_err(3'b000, 32'h1003)), 32'd0);

        clr();
        rst = 1;
        tick();
        rst = 1;
        exp_set(0, 0, 0, 1, 0, 0, 0, 0);
        chk_en = 1;
        idle_cycles(2);

        // Directed cases from the load semantics.
        do_load(3'b000, 32'h1003, 5'd1, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b100, 32'h1003, 5'd2, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b001, 32'h2002, 5'd3, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b101, 32'h2002, 5'd4, 32'h80FF_1234, 1, 2, 1, 0, 0, 0);
        do_load(3'b010, 32'h2000, 5'd5, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b010, 32'h1002, 5'd6, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b001, 32'h1001, 5'd7, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b011, 32'h1000, 5'd8, 32'h80FF_1234, 0, 0, 0, 0, 0, 0);
        do_load(3'b010, 32'h3000, 5'd9, 32'h1111_2222, 0, 3, 0, 2, 1, 0);
        do_load(3'b010, 32'h3004, 5'd10, 32'h1111_2222, 0, TIMEOUT, 3, 0, 0, 0);
        do_load(3'b010, 32'h4000, 5'd11, 32'hAAAA_5555, 2, 0, 0, 4, 1, 0);
        do_load(3'b000, 32'h4001, 5'd12, 32'hAAAA_5555, 0, 1, 2, 5, 1, 0);
        do_load(3'b010, 32'h4008, 5'd13, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0);
        do_load(3'b010, 32'h5000, 5'd14, 32'h0, 1, 1, 0, 1, 0, 0);
        do_load(3'b010, 32'h5000, 5'd15, 32'h0, 1, 1, 0, 1, 1, 2);
        do_load(3'b010, 32'h5000, 5'd16, 32'h1234_5678, 0, 2, 0, 2, 2, 0);
        do_load(3'b000, 32'h5002, 5'd17, 32'h1234_5678, 0, 0, 2, 3, 1, 0);
        idle_cycles(2);

        for (int n = 0; n < 300; n++) begin
            f3 = ($urandom % 8 == 0) ? bad_f3[$urandom % 3] : legal_f3[$urandom % 5];
            a  = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            rdy  = $urandom % 4;
            rsp  = ($urandom % 20 == 0) ? TIMEOUT : int'($urandom % 5);
            wb   = $urandom % 4;
            dd   = $urandom % 5;
            mode = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 5));
            if (model_err(f3, a) != 0 && (mode == 1 || mode == 2 || mode == 4)) mode = 0;
            if (rsp >= TIMEOUT && mode == 2) mode = 0;
            case (mode)
                1, 4:    at = $urandom_range(0, rdy);
                2:       at = $urandom_range(0, rsp);
                3, 5:    at = $urandom_range(0, wb);
                default: at = 0;
            endcase
            do_load(f3, a, 5'($urandom), $urandom, rdy, rsp, wb, mode, at, dd);
            idle_cycles($urandom % 3);
        end

        tick();
        clr();
        exp_idle();
        tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
